vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; next generation of the fixed 640x480 VGA controller.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 82 ++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode parameter sets and the
// derivations used to turn porch/sync widths into counter thresholds.
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    localparam vga_mode_t VGA_800x600_60 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus region decode of the
// current (pre-increment) count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             in_active,
    output logic             in_sync
);

    localparam int unsigned TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_BEG = sync_start(ACTIVE, FP);
    localparam int unsigned SYNC_END = SYNC_BEG + SYNC;
    localparam int unsigned XW       = CNT_W + 1;

    if ((64'd1 << CNT_W) < 64'(TOTAL)) begin : g_width_check
        $error("vga_axis_counter: CNT_W too small for axis total");
    end

    // One spare bit so thresholds equal to 2**CNT_W still compare correctly
    logic [XW-1:0] cnt_x;
    assign cnt_x     = {1'b0, cnt};
    assign wrap      = (cnt_x == XW'(TOTAL - 1));
    assign in_active = (cnt_x < XW'(ACTIVE));
    assign in_sync   = (cnt_x >= XW'(SYNC_BEG)) && (cnt_x < XW'(SYNC_END));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable; outputs
// are registered from the pre-increment counters (one pixel tick of latency).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 32'(VGA_640x480_60.h_active),
    parameter int unsigned H_FP     = 32'(VGA_640x480_60.h_fp),
    parameter int unsigned H_SYNC   = 32'(VGA_640x480_60.h_sync),
    parameter int unsigned H_BP     = 32'(VGA_640x480_60.h_bp),
    parameter int unsigned V_ACTIVE = 32'(VGA_640x480_60.v_active),
    parameter int unsigned V_FP     = 32'(VGA_640x480_60.v_fp),
    parameter int unsigned V_SYNC   = 32'(VGA_640x480_60.v_sync),
    parameter int unsigned V_BP     = 32'(VGA_640x480_60.v_bp),
    parameter bit          HS_POL   = VGA_640x480_60.hs_pol,
    parameter bit          VS_POL   = VGA_640x480_60.vs_pol,
    parameter int unsigned CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             vblank,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap, h_active, h_sync;
    logic             v_wrap, v_active, v_sync;
    logic             v_en;
    // Set while the counters sit at the frame origin (after reset or a full-frame wrap)
    logic             at_origin;

    assign v_en = pix_ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .en(pix_ce),
        .cnt(h_cnt), .wrap(h_wrap), .in_active(h_active), .in_sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .en(v_en),
        .cnt(v_cnt), .wrap(v_wrap), .in_active(v_active), .in_sync(v_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin   <= 1'b1;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            vblank      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            at_origin   <= h_wrap & v_wrap;
            hsync       <= h_sync ? HS_POL : ~HS_POL;
            vsync       <= v_sync ? VS_POL : ~VS_POL;
            de          <= h_active & v_active;
            vblank      <= ~v_active;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= at_origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance and a tiny 8x6-total instance
// with inverted sync polarity, sharing clock, reset and pixel enable.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;

    logic        hsync, vsync, de, vblank, line_start, frame_start;
    logic [10:0] pixel_x, pixel_y;

    logic        s_hsync, s_vsync, s_de, s_vblank, s_line_start, s_frame_start;
    logic [2:0]  s_pixel_x, s_pixel_y;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hsync(hsync), .vsync(vsync), .de(de), .vblank(vblank),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(3)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .vblank(s_vblank),
        .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
        .line_start(s_line_start), .frame_start(s_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, hs_first, hs_last, de_cnt, ls_cnt, fs_cnt, vb_cnt;
        int s_fs, s_vs, s_de_cnt, s_hs, s_vb, s_ls;
        int n, trk_err, strb_err, ls_first, ls_last, ls_n;

        rst    = 1'b1;
        pix_ce = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_hsync",  32'(hsync), 1);
        check("rst_vsync",  32'(vsync), 1);
        check("rst_de",     32'(de), 0);
        check("rst_vblank", 32'(vblank), 0);
        check("rst_x",      32'(pixel_x), 0);
        check("rst_y",      32'(pixel_y), 0);
        check("rst_ls",     32'(line_start), 0);
        check("rst_fs",     32'(frame_start), 0);
        check("rst_s_hsync", 32'(s_hsync), 0);
        check("rst_s_vsync", 32'(s_vsync), 0);

        // Free run for one full default line
        rst = 1'b0;
        hs_low = 0; hs_first = 0; hs_last = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; vb_cnt = 0;
        s_fs = 0; s_vs = 0; s_de_cnt = 0; s_hs = 0; s_vb = 0; s_ls = 0;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (k == 1) begin
                check("e1_x",  32'(pixel_x), 0);
                check("e1_y",  32'(pixel_y), 0);
                check("e1_de", 32'(de), 1);
                check("e1_fs", 32'(frame_start), 1);
                check("e1_ls", 32'(line_start), 1);
                check("e1_s_fs", 32'(s_frame_start), 1);
                check("e1_s_de", 32'(s_de), 1);
            end
            if (k == 48) begin
                check("s48_x", 32'(s_pixel_x), 7);
                check("s48_y", 32'(s_pixel_y), 5);
                check("s48_fs", 32'(s_frame_start), 0);
            end
            if (k == 49) begin
                check("s49_x",  32'(s_pixel_x), 0);
                check("s49_y",  32'(s_pixel_y), 0);
                check("s49_fs", 32'(s_frame_start), 1);
            end
            if (k == 800) begin
                check("e800_x",  32'(pixel_x), 799);
                check("e800_de", 32'(de), 0);
            end
            if (hsync == 1'b0) begin
                if (hs_low == 0) hs_first = k;
                hs_last = k;
                hs_low++;
            end
            if (de) de_cnt++;
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            if (vblank) vb_cnt++;
            if (s_frame_start) s_fs++;
            if (s_line_start) s_ls++;
            if (s_vsync) s_vs++;
            if (s_de) s_de_cnt++;
            if (s_hsync) s_hs++;
            if (s_vblank) s_vb++;
        end
        check("hs_low_cnt",   32'(hs_low), 96);
        check("hs_first_edge", 32'(hs_first), 657);
        check("hs_last_edge",  32'(hs_last), 752);
        check("de_per_line",  32'(de_cnt), 640);
        check("ls_per_line",  32'(ls_cnt), 1);
        check("fs_per_line",  32'(fs_cnt), 1);
        check("vblank_line0", 32'(vb_cnt), 0);
        check("s_fs_cnt",     32'(s_fs), 17);
        check("s_ls_cnt",     32'(s_ls), 100);
        check("s_vsync_cnt",  32'(s_vs), 128);
        check("s_de_cnt",     32'(s_de_cnt), 204);
        check("s_hsync_cnt",  32'(s_hs), 200);
        check("s_vblank_cnt", 32'(s_vb), 392);

        // Second line start
        tick();
        check("e801_x",  32'(pixel_x), 0);
        check("e801_y",  32'(pixel_y), 1);
        check("e801_ls", 32'(line_start), 1);
        check("e801_fs", 32'(frame_start), 0);
        check("e801_de", 32'(de), 1);

        // pix_ce alternating 0,1: outputs hold on idle edges, strobes 1 clk wide
        n = 800; trk_err = 0; strb_err = 0; ls_first = 0; ls_last = 0; ls_n = 0;
        for (int c = 1; c <= 3200; c++) begin
            pix_ce = (c % 2 == 0);
            tick();
            if (pix_ce) n++;
            if (32'(pixel_x) != 32'(n % 800) || 32'(pixel_y) != 32'(n / 800)
                || de !== ((n % 800) < 640)) trk_err++;
            if (!pix_ce && (line_start || frame_start)) strb_err++;
            if (line_start) begin
                if (ls_n == 0) ls_first = c;
                ls_last = c;
                ls_n++;
            end
        end
        check("ce_track_err",  32'(trk_err), 0);
        check("ce_strobe_err", 32'(strb_err), 0);
        check("ce_ls_count",   32'(ls_n), 2);
        check("ce_ls_first",   32'(ls_first), 1600);
        check("ce_line_period", 32'(ls_last - ls_first), 1600);
        check("ce_end_y",      32'(pixel_y), 3);

        // Advance into the hsync pulse, then reset mid-line
        pix_ce = 1'b1;
        for (int k = 0; k < 660; k++) tick();
        check("pre_x",       32'(pixel_x), 660);
        check("pre_y",       32'(pixel_y), 3);
        check("pre_hsync",   32'(hsync), 0);
        check("pre_s_vsync", 32'(s_vsync), 1);
        check("pre_s_vblank", 32'(s_vblank), 1);

        rst = 1'b1;
        tick();
        check("mrst_hsync",  32'(hsync), 1);
        check("mrst_de",     32'(de), 0);
        check("mrst_x",      32'(pixel_x), 0);
        check("mrst_y",      32'(pixel_y), 0);
        check("mrst_fs",     32'(frame_start), 0);
        check("mrst_s_vsync", 32'(s_vsync), 0);
        check("mrst_s_vblank", 32'(s_vblank), 0);

        // Released with pix_ce low: reset values hold until the first tick
        rst    = 1'b0;
        pix_ce = 1'b0;
        tick();
        tick();
        check("idle_de",    32'(de), 0);
        check("idle_fs",    32'(frame_start), 0);
        check("idle_hsync", 32'(hsync), 1);

        pix_ce = 1'b1;
        tick();
        check("post_x",  32'(pixel_x), 0);
        check("post_y",  32'(pixel_y), 0);
        check("post_de", 32'(de), 1);
        check("post_fs", 32'(frame_start), 1);
        check("post_ls", 32'(line_start), 1);
        check("post_s_fs", 32'(s_frame_start), 1);
        check("post_s_hsync", 32'(s_hsync), 0);

        tick();
        check("post2_x",  32'(pixel_x), 1);
        check("post2_fs", 32'(frame_start), 0);
        check("post2_ls", 32'(line_start), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
